// File: rtl/apb_uart_tx_pkg.sv
// rtl/apb_uart_tx_pkg.sv - shared types and UART register map for apb_uart_tx_master
package apb_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SETUP  = 3'd1,
    RD_ACCESS = 3'd2,
    WR_SETUP  = 3'd3,
    WR_ACCESS = 3'd4
  } tx_state_e;

  localparam logic [31:0] UartThrOffset = 32'h0000_0000;
  localparam logic [31:0] UartLsrOffset = 32'h0000_0014;
  localparam int unsigned LsrThreBit    = 5;

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - circular FIFO with optional fall-through and occupancy output
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned CntW = ADDR_DEPTH + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  assign full_o  = (cnt_q == DepthCnt);
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
  // usage wraps to 0 when full, so callers combine it with full_o
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];

  // pointer/count update; pointers wrap naturally because DEPTH is a power of 2
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    data_o   = mem_q[rd_ptr_q];
    if (push_i && !full_o) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      cnt_d           = cnt_q + 1'b1;
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !full_o) cnt_d = cnt_q;
      else                   cnt_d = cnt_q - 1'b1;
    end
    if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
      data_o = data_i;
      if (pop_i) begin
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
      end
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // storage and pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/apb_uart_tx_master.sv
// rtl/apb_uart_tx_master.sv - APB requester draining a byte FIFO into a UART THR; LSR polling under UART_TX_LSR_POLL_EN
module apb_uart_tx_master
  import apb_uart_tx_pkg::*;
#(
  parameter int unsigned FifoDepth = 8,
  parameter logic [31:0] BaseAddr  = 32'hC000_0000,
  parameter int unsigned MaxPolls  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  localparam int unsigned FifoAw = $clog2(FifoDepth);

  tx_state_e state_q, state_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic        err_q, err_d;
  logic        err_set;

  logic              fifo_full;
  logic              fifo_empty;
  logic [FifoAw-1:0] fifo_usage;
  logic [7:0]        fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              more_after_pop;

`ifdef UART_TX_LSR_POLL_EN
  localparam int unsigned PollW = $clog2(MaxPolls + 1);
  logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
  logic unused_prdata;
  assign unused_prdata = ^{prdata_i[31:LsrThreBit+1], prdata_i[LsrThreBit-1:0]};
`else
  localparam int unsigned unused_max_polls = MaxPolls;
  logic unused_prdata;
  assign unused_prdata = ^prdata_i;
`endif

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (8),
    .DEPTH        (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage),
    .data_i  (data_i),
    .push_i  (fifo_push),
    .data_o  (fifo_head),
    .pop_i   (fifo_pop)
  );

  assign ready_o   = !fifo_full;
  assign fifo_push = valid_i && !fifo_full;
  assign busy_o    = (state_q != IDLE) || !fifo_empty;
  // a full FIFO reports usage 0, so treat full as "more than one byte"
  assign more_after_pop = fifo_full || (fifo_usage > FifoAw'(1));

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  // head only advances on the WR_ACCESS pop, so it is stable for the whole write
  assign pwdata_o  = pwrite_q ? {24'h0, fifo_head} : 32'h0;
  assign err_o     = err_q;

  // next-state, pop and error decisions
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    err_set  = 1'b0;
`ifdef UART_TX_LSR_POLL_EN
    poll_cnt_d = poll_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
`ifdef UART_TX_LSR_POLL_EN
          state_d = RD_SETUP;
`else
          state_d = WR_SETUP;
`endif
        end
      end
`ifdef UART_TX_LSR_POLL_EN
      RD_SETUP: state_d = RD_ACCESS;
      RD_ACCESS: begin
        if (pready_i) begin
          if (prdata_i[LsrThreBit] && !pslverr_i) begin
            state_d = WR_SETUP;
          end else if (poll_cnt_q == PollW'(MaxPolls - 1)) begin
            fifo_pop   = 1'b1;
            err_set    = 1'b1;
            poll_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
            state_d    = RD_SETUP;
          end
        end
      end
`endif
      WR_SETUP: state_d = WR_ACCESS;
      WR_ACCESS: begin
        if (pready_i) begin
          fifo_pop = 1'b1;
`ifdef UART_TX_LSR_POLL_EN
          poll_cnt_d = '0;
`endif
          if (pslverr_i) err_set = 1'b1;
          if (more_after_pop) begin
`ifdef UART_TX_LSR_POLL_EN
            state_d = RD_SETUP;
`else
            state_d = WR_SETUP;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = err_set || (err_q && !err_clr_i);
  end

  // APB controls decoded from the next state so they leave the flops with the state
  always_comb begin
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = 1'b0;
    paddr_d   = 32'h0;
    case (state_d)
      RD_SETUP: begin
        psel_d  = 1'b1;
        paddr_d = BaseAddr + UartLsrOffset;
      end
      RD_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        paddr_d   = BaseAddr + UartLsrOffset;
      end
      WR_SETUP: begin
        psel_d   = 1'b1;
        pwrite_d = 1'b1;
        paddr_d  = BaseAddr + UartThrOffset;
      end
      WR_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        pwrite_d  = 1'b1;
        paddr_d   = BaseAddr + UartThrOffset;
      end
      default: ;
    endcase
  end

  // state, APB output and error registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      err_q     <= err_d;
    end
  end

`ifdef UART_TX_LSR_POLL_EN
  // per-byte LSR poll counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) poll_cnt_q <= '0;
    else         poll_cnt_q <= poll_cnt_d;
  end
`endif

endmodule

// File: tb/tb_apb_uart_tx_master.sv
// tb/tb_apb_uart_tx_master.sv - directed self-checking bench for apb_uart_tx_master
module tb_apb_uart_tx_master;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        ready_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o;
  logic [31:0] prdata_i = 32'h0;
  logic        pready_i;
  logic        pslverr_i = 1'b0;
  logic        busy_o, err_o, err_clr_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wr_log[$];
  logic [31:0] rd_log[$];
  logic [31:0] lsr_q[$];
  logic [31:0] lsr_default = 32'h20;
  logic        slverr_en = 1'b0;

  always #5 clk_i = ~clk_i;

  apb_uart_tx_master #(
    .FifoDepth (8),
    .BaseAddr  (32'hC000_0000),
    .MaxPolls  (4)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .pwrite_o  (pwrite_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i),
    .busy_o    (busy_o),
    .err_o     (err_o),
    .err_clr_i (err_clr_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // UART responder and transfer log: drives LSR data/slave error, records completed accesses
  always @(negedge clk_i) begin
    #1;
    prdata_i  = (lsr_q.size() > 0) ? lsr_q[0] : lsr_default;
    pslverr_i = slverr_en & pwrite_o;
    #1;
    if (rst_ni && psel_o && penable_o && pready_i) begin
      if (pwrite_o) wr_log.push_back(pwdata_o);
      else begin
        rd_log.push_back(paddr_o);
        if (lsr_q.size() > 0) void'(lsr_q.pop_front());
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    data_i  = b;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while (busy_o && n < max_cycles) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, busy_o, 0);
  endtask

  task automatic wait_access(input string tag, input int max_cycles);
    int n = 0;
    while (!(psel_o && penable_o) && n < max_cycles) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, psel_o && penable_o, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_ni    = 1'b0;
    data_i    = 8'h0;
    valid_i   = 1'b0;
    pready_i  = 1'b1;
    err_clr_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0);
    chk("rst_pwrite", pwrite_o, 0);
    chk("rst_paddr", paddr_o, 32'h0);
    chk("rst_pwdata", pwdata_o, 32'h0);
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // direct write of 8'h41
    wr_log.delete();
    push_byte(8'h41);
`ifndef UART_TX_LSR_POLL_EN
    chk("c1_busy", busy_o, 1);
    chk("c1_psel", psel_o, 0);
    @(negedge clk_i);
    chk("c2_psel", psel_o, 1);
    chk("c2_penable", penable_o, 0);
    chk("c2_pwrite", pwrite_o, 1);
    chk("c2_paddr", paddr_o, 32'hC000_0000);
    chk("c2_pwdata", pwdata_o, 32'h41);
    @(negedge clk_i);
    chk("c3_psel", psel_o, 1);
    chk("c3_penable", penable_o, 1);
    chk("c3_pwdata", pwdata_o, 32'h41);
    @(negedge clk_i);
    chk("c4_psel", psel_o, 0);
    chk("c4_busy", busy_o, 0);
`else
    wait_idle("direct_idle", 20);
`endif
    chk("direct_wr_count", wr_log.size(), 1);
    chk("direct_wr_data", (wr_log.size() > 0) ? wr_log[0] : 32'hDEAD_BEEF, 32'h41);

    // fill with pready low, then drain
    wr_log.delete();
    pready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      data_i  = 8'h10 + 8'(i);
      valid_i = 1'b1;
      @(negedge clk_i);
      chk($sformatf("fill_ready%0d", i), ready_o, 32'(i < 7));
    end
    pready_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!ready_o && n < 10);
`ifdef UART_TX_LSR_POLL_EN
    chk("ready_rise_latency", n, 3);
`else
    chk("ready_rise_latency", n, 1);
`endif
    chk("first_pop_count", wr_log.size(), 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    wait_idle("drain_idle", 80);
    chk("drain_count", wr_log.size(), 9);
    for (int k = 0; k < 9; k++)
      chk($sformatf("drain_byte%0d", k), (k < wr_log.size()) ? wr_log[k] : 32'hDEAD_BEEF,
          32'h10 + 32'(k));
    chk("drain_err", err_o, 0);

    // slave error on the THR write
    wr_log.delete();
    slverr_en = 1'b1;
    push_byte(8'h55);
    wait_idle("slverr_idle", 20);
    chk("slverr_err", err_o, 1);
    chk("slverr_popped", wr_log.size(), 1);
    push_byte(8'h56);
    wait_access("slverr2_access", 20);
    chk("slverr2_pwrite", pwrite_o, 1);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    chk("err_set_beats_clr", err_o, 1);
    chk("slverr2_busy", busy_o, 0);
    slverr_en = 1'b0;
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    chk("err_clr", err_o, 0);

`ifdef UART_TX_LSR_POLL_EN
    // LSR busy three times, then THRE
    wr_log.delete();
    rd_log.delete();
    lsr_q.push_back(32'h0);
    lsr_q.push_back(32'h0);
    lsr_q.push_back(32'h0);
    lsr_q.push_back(32'h20);
    push_byte(8'h5A);
    wait_idle("poll_idle", 40);
    chk("poll_reads", rd_log.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("poll_addr%0d", k), (k < rd_log.size()) ? rd_log[k] : 32'hDEAD_BEEF,
          32'hC000_0014);
    chk("poll_writes", wr_log.size(), 1);
    chk("poll_wdata", (wr_log.size() > 0) ? wr_log[0] : 32'hDEAD_BEEF, 32'h5A);
    chk("poll_err", err_o, 0);

    // timeout: THRE never set
    wr_log.delete();
    rd_log.delete();
    lsr_default = 32'h0;
    push_byte(8'h66);
    wait_idle("timeout_idle", 40);
    chk("timeout_reads", rd_log.size(), 4);
    chk("timeout_writes", wr_log.size(), 0);
    chk("timeout_err", err_o, 1);
    lsr_default = 32'h20;
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    wr_log.delete();
    rd_log.delete();
    push_byte(8'h77);
    wait_idle("after_timeout_idle", 40);
    chk("after_timeout_reads", rd_log.size(), 1);
    chk("after_timeout_wdata", (wr_log.size() > 0) ? wr_log[0] : 32'hDEAD_BEEF, 32'h77);
    chk("after_timeout_err", err_o, 0);
`endif

    // reset in the middle of an access
    wr_log.delete();
    slverr_en = 1'b1;
    pready_i  = 1'b0;
    push_byte(8'h99);
    push_byte(8'h9A);
    wait_access("rst_mid_access", 20);
    pready_i = 1'b1;
    @(negedge clk_i);
    pready_i = 1'b0;
    chk("rst_mid_err_before", err_o, 1);
    wait_access("rst_mid_access2", 20);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_psel", psel_o, 0);
    chk("mid_rst_penable", penable_o, 0);
    chk("mid_rst_pwrite", pwrite_o, 0);
    chk("mid_rst_paddr", paddr_o, 32'h0);
    chk("mid_rst_pwdata", pwdata_o, 32'h0);
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_err", err_o, 0);
    slverr_en = 1'b0;
    @(negedge clk_i);
    rst_ni   = 1'b1;
    pready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_psel", psel_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_uart_tx_master.md
# apb_uart_tx_master

APB requester that drains a byte stream into a 16550-style UART over APB, i.e. the initiator side of the APB link whose responder is `mock_uart`. It sits between a byte producer and the UART APB port, and lets benches or a bare-metal-free test path print characters without the scalar core. A small FIFO decouples the producer. An optional poll of the UART line-status register paces writes.

## Interface
- `FifoDepth`, default 8: byte FIFO entries; must be a power of 2 and at least 2.
- `BaseAddr`, default 32'hC000_0000: UART base address.
- `MaxPolls`, default 1024: LSR reads allowed per byte before the byte is dropped.
- `clk_i` in 1: clock. Single clock domain.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `data_i` in 8: byte to transmit.
- `valid_i` in 1: `data_i` is valid.
- `ready_o` out 1: FIFO not full.
- `psel_o`, `penable_o`, `pwrite_o` out 1 each: APB control.
- `paddr_o` out 32: APB address.
- `pwdata_o` out 32: APB write data. Byte in [7:0], zeros above.
- `prdata_i` in 32: APB read data.
- `pready_i`, `pslverr_i` in 1 each: APB response.
- `busy_o` out 1: FIFO non-empty or FSM not IDLE.
- `err_o` out 1: sticky error flag.
- `err_clr_i` in 1: clears `err_o`.

## Operation
- **Push.** A push occurs in a cycle where `valid_i & ready_o` is high.
  - `ready_o = !full`.
  - When full, `ready_o` is low and nothing is pushed, even if a pop happens in the same cycle.
- **FSM states:** IDLE, RD_SETUP, RD_ACCESS, WR_SETUP, WR_ACCESS.
- **IDLE:**
  - If the FIFO is non-empty, go to RD_SETUP when polling is compiled in.
  - Otherwise go to WR_SETUP.
- **RD_SETUP:** `psel=1`, `penable=0`, `pwrite=0`, `paddr = BaseAddr + 32'h14` (LSR). Next state RD_ACCESS.
- **RD_ACCESS:** `psel=1`, `penable=1`. Hold until `pready_i`. On `pready_i`:
  - If `prdata_i[5]` (THRE) is high and `pslverr_i` is low: go to WR_SETUP.
  - Otherwise increment the poll counter.
  - If the counter reaches `MaxPolls`: pop and drop the byte, set `err_o`, go to IDLE.
  - Otherwise go to RD_SETUP.
- **WR_SETUP:** `psel=1`, `penable=0`, `pwrite=1`, `paddr = BaseAddr` (THR), `pwdata = {24'h0, fifo head}`. Next state WR_ACCESS.
- **WR_ACCESS:** `psel=1`, `penable=1`, all other APB outputs held stable. On `pready_i`:
  - Pop the FIFO and clear the poll counter.
  - If `pslverr_i` is high, set `err_o`. The byte counts as consumed.
  - Next state: WR_SETUP, or RD_SETUP if polling, when the FIFO holds another byte after the pop. Otherwise IDLE.
- **Poll counter:** width `$clog2(MaxPolls+1)`. It is cleared on every pop and never wraps.
- **`err_o`:** set has priority over `err_clr_i` in the same cycle.

## Timing
- All APB outputs are registered, decoded from the state register and held registers.
- Reset values: `psel_o=0`, `penable_o=0`, `pwrite_o=0`, `paddr_o=0`, `pwdata_o=0`, `ready_o=1`, `busy_o=0`, `err_o=0`. FSM starts in IDLE, FIFO empty, poll counter 0.
- Latency, with the handshake in cycle 0:
  - Cycle 1: FIFO non-empty.
  - Cycle 2: first SETUP cycle.
  - Without polling and with zero wait states, the THR access completes in cycle 3 and the pop takes effect at the end of cycle 3.
- Back-to-back writes without polling take 2 cycles per byte. There are no idle cycles between transfers.
- Wait states: any number of low-`pready_i` cycles in ACCESS is legal. Outputs stay frozen.
- Reset mid-transfer: all outputs return to reset values asynchronously and FIFO contents are lost. The APB slave sees the transfer aborted.
- `busy_o` is combinational from state and FIFO count. It is low only in IDLE with an empty FIFO.

## Configuration
- `UART_TX_LSR_POLL_EN`:
  - When defined, the RD_SETUP/RD_ACCESS states, the poll counter and the `MaxPolls` timeout are compiled in.
  - When undefined, those states and the counter are absent. IDLE goes straight to WR_SETUP, `prdata_i` is unused, and `err_o` is set only by a `pslverr_i` on a write.

## Structure
- Package `apb_uart_tx_pkg` holds:
  - the state enum `tx_state_e`;
  - the offsets `UartThrOffset = 32'h0` and `UartLsrOffset = 32'h14`;
  - `LsrThreBit = 5`.
- The FIFO is `fifo_v3` from common_cells (`DATA_WIDTH=8`, `DEPTH=FifoDepth`, fall-through off). It is the only sub-module.

## Test plan
- **Direct write, no polling:** push 8'h41 in cycle 0 with `pready_i` tied high. Required: `psel_o` rises in cycle 2, `pwrite_o=1`, `paddr_o=32'hC000_0000`, `pwdata_o=32'h41`, transfer completes in cycle 3, `busy_o` low in cycle 4.
- **Fill and drain:** push 9 bytes with `pready_i` held low. Required: `ready_o` drops after the 8th push. Release `pready_i`; required: bytes are written in order and `ready_o` rises the cycle after the first pop.
- **Poll wait:** LSR returns 32'h00 three times, then 32'h20. Required: 4 LSR reads at address 32'hC000_0014, then exactly one THR write, `err_o` stays 0.
- **Poll timeout** with `MaxPolls=4`: LSR always returns 0. Required: 4 reads, the byte is dropped, `err_o` goes high, and the next byte proceeds normally.
- **Slave error:** `pslverr_i` high on a THR write. Required: the byte is popped and `err_o` is set. Assert `err_clr_i` and an error in the same cycle; required: `err_o` stays 1.
- **Reset mid-access:** deassert `rst_ni` during WR_ACCESS. Required: all outputs are 0 immediately and `ready_o=1`.
